// File: rtl/color_config_bus_master.sv
// Configuration-bus initiator: turns framed UART command bytes into single bus writes
// and answers each completed write with a one-byte ACK/NAK status.
module color_config_bus_master #(
    parameter int         C_ADDR_WIDTH = 4,
    parameter int         C_DATA_WIDTH = 16,
    parameter int         DATA_BYTES   = 2,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         ACK_TIMEOUT  = 1023,
    parameter int         GAP_TIMEOUT  = 100000,
    parameter int         CNT_WIDTH    = 17
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [7:0]              Rx_Data,
    input  logic                    Rx_Valid,
    output logic [7:0]              Tx_Data,
    output logic                    Tx_Valid,
    input  logic                    Tx_Rdy,
    output logic [C_ADDR_WIDTH-1:0] C_Addr,
    output logic [C_DATA_WIDTH-1:0] C_Data,
    output logic                    C_Valid,
    input  logic                    C_Rdy,
    output logic                    Busy,
    output logic                    Rx_Drop,
    output logic [2:0]              Dbg_State
);

    localparam int                   DW        = DATA_BYTES * 8;
    localparam int                   BCW       = $clog2(DATA_BYTES + 1);
    localparam logic [BCW-1:0]       LAST_BYTE = BCW'(DATA_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] ACK_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TIMEOUT - 1);
    localparam logic [7:0]           ACK_BYTE  = 8'h06;
    localparam logic [7:0]           NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_WAIT_REL = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t                    r_state;
    logic [CNT_WIDTH-1:0]      r_timer;
    logic [BCW-1:0]            r_byte_cnt;
    logic [DW-1:0]             r_data;
    logic [C_ADDR_WIDTH-1:0]   r_addr;
    logic                      r_c_valid;
    logic                      r_tx_valid;
    logic [7:0]                r_tx_data;
    logic                      r_busy;
    logic                      r_rx_drop;
    logic [DW-1:0]             w_data_shift;

    // Bytes arrive most-significant first, so each new byte enters at the bottom.
    assign w_data_shift = (r_data << 8) | DW'(Rx_Data);

    // Handshakes: Rx is a one-cycle strobe with no backpressure; Tx_Valid/Tx_Data
    // hold until the first cycle Tx_Rdy is high; C_Valid is a one-cycle strobe
    // issued only while C_Rdy is high, and the slave acknowledges by pulling C_Rdy
    // low then releasing it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_byte_cnt <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_c_valid  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_rx_drop  <= 1'b0;
        end else begin
            r_rx_drop <= Rx_Valid && r_busy;
            r_c_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Rx_Valid && (Rx_Data == HEADER)) begin
                        r_state <= S_ADDR;
                        r_timer <= '0;
                    end
                end
                S_ADDR: begin
                    if (Rx_Valid) begin
                        r_addr     <= Rx_Data[C_ADDR_WIDTH-1:0];
                        r_byte_cnt <= '0;
                        r_timer    <= '0;
                        r_state    <= S_DATA;
                    end else if (r_timer == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (Rx_Valid) begin
                        r_data  <= w_data_shift;
                        r_timer <= '0;
                        if (r_byte_cnt == LAST_BYTE) begin
                            // Strobe straight away when the slave is already ready.
                            r_state   <= S_ISSUE;
                            r_busy    <= 1'b1;
                            r_c_valid <= C_Rdy;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end else if (r_timer == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_c_valid) begin
                        // A slave that pulls C_Rdy low during the strobe has already acknowledged.
                        r_timer <= '0;
                        r_state <= C_Rdy ? S_WAIT_ACK : S_WAIT_REL;
                    end else begin
                        r_c_valid <= C_Rdy;
                    end
                end
                S_WAIT_ACK: begin
                    if (!C_Rdy) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_REL;
                    end else if (r_timer == ACK_LAST) begin
                        r_tx_data  <= NAK_BYTE;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (C_Rdy) begin
                        r_tx_data  <= ACK_BYTE;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (r_timer == ACK_LAST) begin
                        r_tx_data  <= NAK_BYTE;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (Tx_Rdy) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Tx_Data   = r_tx_data;
    assign Tx_Valid  = r_tx_valid;
    assign C_Addr    = r_addr;
    assign C_Data    = r_data[C_DATA_WIDTH-1:0];
    assign C_Valid   = r_c_valid;
    assign Busy      = r_busy;
    assign Rx_Drop   = r_rx_drop;
    assign Dbg_State = r_state;

endmodule

// File: tb/tb_color_config_bus_master.sv
// Directed bench for color_config_bus_master: scoreboard queues for bus writes and
// status bytes, with short timeouts so every scenario fits in a few thousand cycles.
module tb_color_config_bus_master;

    localparam int ACK_TO = 40;
    localparam int GAP_TO = 60;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd4;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Rx_Data = 8'h00;
    logic       Rx_Valid = 1'b0;
    logic       Tx_Rdy = 1'b1;
    logic       C_Rdy = 1'b1;
    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic [3:0] C_Addr;
    logic [15:0] C_Data;
    logic       C_Valid;
    logic       Busy;
    logic       Rx_Drop;
    logic [2:0] Dbg_State;

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] bus_q[$];
    logic [7:0]  tx_q[$];
    bit slave_ack = 1'b0;

    color_config_bus_master #(
        .C_ADDR_WIDTH(4),
        .C_DATA_WIDTH(16),
        .DATA_BYTES  (2),
        .HEADER      (8'hA5),
        .ACK_TIMEOUT (ACK_TO),
        .GAP_TIMEOUT (GAP_TO),
        .CNT_WIDTH   (17)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Rx_Data  (Rx_Data),
        .Rx_Valid (Rx_Valid),
        .Tx_Data  (Tx_Data),
        .Tx_Valid (Tx_Valid),
        .Tx_Rdy   (Tx_Rdy),
        .C_Addr   (C_Addr),
        .C_Data   (C_Data),
        .C_Valid  (C_Valid),
        .C_Rdy    (C_Rdy),
        .Busy     (Busy),
        .Rx_Drop  (Rx_Drop),
        .Dbg_State(Dbg_State)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: all start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_Data  = b;
        Rx_Valid = 1'b1;
        @(posedge Clk);
        #1;
        Rx_Valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                              input int gap);
        bus_q.push_back({a[3:0], hi, lo});
        send_byte(8'hA5);
        idle(gap);
        send_byte(a);
        idle(gap);
        send_byte(hi);
        idle(gap);
        send_byte(lo);
    endtask

    task automatic wait_tx(input int max, output int n);
        n = 0;
        while (Tx_Valid !== 1'b1 && n < max) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("tx_arrives", {31'd0, Tx_Valid}, 32'd1);
    endtask

    // slave model: acknowledges by pulling C_Rdy low for one cycle after the strobe
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (slave_ack && C_Valid === 1'b1) begin
                @(posedge Clk);
                #1;
                C_Rdy = 1'b0;
                @(posedge Clk);
                #1;
                C_Rdy = 1'b1;
            end
        end
    end

    // scoreboard
    always @(negedge Clk) begin
        if (!Rst && C_Valid === 1'b1) begin
            if (bus_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL bus_unexpected: observed addr %0h data %0h expected no write", C_Addr, C_Data);
            end else begin
                check("bus_write", {12'd0, C_Addr, C_Data}, {12'd0, bus_q.pop_front()});
            end
        end
        if (!Rst && Tx_Valid === 1'b1 && Tx_Rdy === 1'b1) begin
            if (tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL tx_unexpected: observed %0h expected no status byte", Tx_Data);
            end else begin
                check("tx_byte", {24'd0, Tx_Data}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        bit tx_seen;
        logic [7:0] ra, rh, rl;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_c_valid", {31'd0, C_Valid}, 32'd0);
        check("rst_tx_valid", {31'd0, Tx_Valid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_state", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
        check("rst_outputs", {C_Addr, C_Data, Tx_Data, Rx_Drop}, 32'd0);
        Rst = 1'b0;

        // non-header bytes in IDLE are ignored
        send_byte(8'h12);
        send_byte(8'h02);
        idle(1);
        check("idle_ignore", {29'd0, Dbg_State}, {29'd0, ST_IDLE});

        // T1 basic write with acknowledge
        slave_ack = 1'b1;
        send_frame(8'h02, 8'h00, 8'h3F, 0);
        check("t1_latency", {31'd0, C_Valid}, 32'd1);
        check("t1_busy", {31'd0, Busy}, 32'd1);
        tx_q.push_back(8'h06);
        wait_tx(20, n);
        check("t1_tx_cycles", n, 3);
        idle(2);
        check("t1_back_idle", {28'd0, Busy, Dbg_State}, {28'd0, 1'b0, ST_IDLE});

        // T2 slave never acknowledges
        slave_ack = 1'b0;
        send_frame(8'h09, 8'hBE, 8'hEF, 0);
        tx_q.push_back(8'h15);
        wait_tx(3 * ACK_TO, n);
        check("t2_nak_cycles", n, ACK_TO + 1);
        check("t2_nak_byte", {24'd0, Tx_Data}, 32'h15);
        idle(2);

        // longest accepted gap, header value as data, high address bits dropped
        slave_ack = 1'b1;
        send_frame(8'hF7, 8'hA5, 8'hA5, GAP_TO - 1);
        check("gap_ok_latency", {31'd0, C_Valid}, 32'd1);
        tx_q.push_back(8'h06);
        wait_tx(20, n);
        check("gap_ok_tx_cycles", n, 3);
        idle(2);

        // T3 gap timeout discards the frame
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(GAP_TO - 1);
        check("t3_before_timeout", {29'd0, Dbg_State}, {29'd0, ST_DATA});
        idle(1);
        check("t3_gap_abort", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
        send_byte(8'h00);
        send_byte(8'h05);
        idle(3);
        check("t3_still_idle", {28'd0, Busy, Dbg_State}, {28'd0, 1'b0, ST_IDLE});

        // random frames
        for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom_range(0, 255));
            rh = 8'($urandom_range(0, 255));
            rl = 8'($urandom_range(0, 255));
            send_frame(ra, rh, rl, $urandom_range(0, 3));
            tx_q.push_back(8'h06);
            wait_tx(20, n);
            check("rand_tx_cycles", n, 3);
            idle(2);
        end

        // T4 slave busy at frame end
        slave_ack = 1'b0;
        C_Rdy = 1'b0;
        send_frame(8'h05, 8'h12, 8'h34, 0);
        for (int i = 0; i < 20; i++) begin
            check("t4_no_valid", {31'd0, C_Valid}, 32'd0);
            check("t4_busy", {31'd0, Busy}, 32'd1);
            idle(1);
        end
        C_Rdy = 1'b1;
        slave_ack = 1'b1;
        tx_q.push_back(8'h06);
        idle(1);
        check("t4_valid_on_rdy", {31'd0, C_Valid}, 32'd1);
        wait_tx(20, n);
        check("t4_tx_cycles", n, 3);
        idle(2);

        // T5 drops during WAIT_ACK and RESP, Tx held under backpressure
        slave_ack = 1'b0;
        send_frame(8'h03, 8'h55, 8'hAA, 0);
        idle(3);
        check("t5_wait_ack", {28'd0, Busy, Dbg_State}, {28'd0, 1'b1, ST_WAIT_ACK});
        send_byte(8'h77);
        check("t5_drop_wait_ack", {31'd0, Rx_Drop}, 32'd1);
        idle(1);
        check("t5_drop_one_cycle", {31'd0, Rx_Drop}, 32'd0);
        Tx_Rdy = 1'b0;
        tx_q.push_back(8'h15);
        wait_tx(3 * ACK_TO, n);
        for (int i = 0; i < 10; i++) begin
            check("t5_tx_hold", {23'd0, Tx_Valid, Tx_Data}, {23'd0, 1'b1, 8'h15});
            if (i == 4) begin
                send_byte(8'hA5);
                check("t5_drop_resp", {31'd0, Rx_Drop}, 32'd1);
            end else begin
                idle(1);
            end
        end
        Rx_Data  = 8'h3C;
        Rx_Valid = 1'b1;
        Tx_Rdy   = 1'b1;
        @(posedge Clk);
        #1;
        Rx_Valid = 1'b0;
        check("t5_drop_on_exit", {31'd0, Rx_Drop}, 32'd1);
        check("t5_exit", {27'd0, Tx_Valid, Busy, Dbg_State}, {27'd0, 1'b0, 1'b0, ST_IDLE});
        idle(2);
        check("t5_no_resync", {29'd0, Dbg_State}, {29'd0, ST_IDLE});

        // T6 reset during WAIT_ACK
        send_frame(8'h0A, 8'h11, 8'h22, 0);
        idle(4);
        check("t6_in_wait_ack", {29'd0, Dbg_State}, {29'd0, ST_WAIT_ACK});
        Rst = 1'b1;
        idle(1);
        check("t6_rst_ctrl", {27'd0, C_Valid, Tx_Valid, Busy, Rx_Drop, 1'b0}, 32'd0);
        check("t6_rst_state", {29'd0, Dbg_State}, {29'd0, ST_IDLE});
        check("t6_rst_data", {4'd0, C_Addr, C_Data, Tx_Data}, 32'd0);
        Rst = 1'b0;
        tx_seen = 1'b0;
        for (int i = 0; i < ACK_TO + 10; i++) begin
            if (Tx_Valid === 1'b1) tx_seen = 1'b1;
            idle(1);
        end
        check("t6_no_status", {31'd0, tx_seen}, 32'd0);

        check("bus_q_empty", bus_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
